// File: rtl/mac_sequencer.sv
// Sequences an external registered multiply-add unit through one bias-seeded dot product per job.
// Define MAC_SEQUENCER_RELU_EN to clamp negative results to zero before they are presented.
module mac_sequencer #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int MAX_TAPS = 25,
    parameter int CNT_W    = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_taps,
    input  logic [ACC_W-1:0]  cfg_bias,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [DATA_W-1:0] mult_dataa,
    output logic [DATA_W-1:0] mult_datab,
    output logic [ACC_W-1:0]  mult_sum,
    output logic              mult_aclr,
    input  logic [ACC_W-1:0]  mult_result
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   taps_reg, count_reg, taps_clamped;
    logic [ACC_W-1:0]   bias_reg, out_data_reg, drain_value;
    logic               last_tap;

    assign last_tap  = (count_reg == taps_reg - CNT_W'(1));
    assign mult_aclr = ~reset_n;
    assign out_data  = out_data_reg;

    // A zero tap count still runs one tap; oversize requests saturate at the kernel size.
    always_comb begin
        taps_clamped = cfg_taps;
        if (cfg_taps == '0)
            taps_clamped = CNT_W'(1);
        else if (cfg_taps > CNT_W'(MAX_TAPS))
            taps_clamped = CNT_W'(MAX_TAPS);
    end

`ifdef MAC_SEQUENCER_RELU_EN
    assign drain_value = mult_result[ACC_W-1] ? '0 : mult_result;
`else
    assign drain_value = mult_result;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (in_valid && last_tap) state_next = DRAIN;
            DRAIN:   state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The multiply-add unit updates every clock, so non-issue cycles feed back
    // its own result with a zero product to keep it steady.
    always_comb begin
        busy       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mult_dataa = '0;
        mult_datab = '0;
        mult_sum   = mult_result;
        if (!reset_n) begin
            mult_sum = '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    busy     = 1'b1;
                    in_ready = 1'b1;
                    if (in_valid) begin
                        mult_dataa = in_a;
                        mult_datab = in_b;
                        mult_sum   = (count_reg == '0) ? bias_reg : mult_result;
                    end
                end
                DRAIN: busy = 1'b1;
                HOLD: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            taps_reg     <= '0;
            bias_reg     <= '0;
            count_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    taps_reg  <= taps_clamped;
                    bias_reg  <= cfg_bias;
                    count_reg <= '0;
                end
                ACCUM: if (in_valid) count_reg <= count_reg + CNT_W'(1);
                DRAIN: out_data_reg <= drain_value;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural model of the registered multiply-add unit.
module tb_mac_sequencer;

    logic        clock = 1'b0;
    logic        reset_n, start, in_valid, out_ready;
    logic [4:0]  cfg_taps;
    logic [23:0] cfg_bias;
    logic        busy, in_ready, out_valid, mult_aclr;
    logic [7:0]  in_a, in_b, mult_dataa, mult_datab;
    logic [23:0] out_data, mult_sum, mult_result;

    logic signed [15:0] prod;
    logic signed [7:0]  a_vec [32];
    logic signed [7:0]  b_vec [32];

    int vectors = 0;
    int errors  = 0;
    int lat, hs;
    logic [23:0] held;

    always #5 clock = ~clock;

    mac_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cfg_taps(cfg_taps),
        .cfg_bias(cfg_bias), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .mult_dataa(mult_dataa), .mult_datab(mult_datab),
        .mult_sum(mult_sum), .mult_aclr(mult_aclr), .mult_result(mult_result)
    );

    // Multiply-add unit: signed, one-cycle latency, synchronous clear.
    assign prod = $signed(mult_dataa) * $signed(mult_datab);
    always_ff @(posedge clock) begin
        if (mult_aclr)
            mult_result <= '0;
        else
            mult_result <= {{8{prod[15]}}, prod} + mult_sum;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a job at cycle 0, feed a_vec/b_vec pairs with an optional stall, and
    // return the cycle on which out_valid rose and the number of handshakes.
    task automatic run_job(input logic [4:0] taps, input logic [23:0] bias, input int npairs,
                           input int stall_at, input int stall_len, output int l, output int h);
        int stalls;
        stalls = 0;
        h = 0;
        cfg_taps = taps;
        cfg_bias = bias;
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (!out_valid && l < 200) begin
            if (h < npairs && !(h == stall_at && stalls < stall_len)) begin
                in_valid = 1'b1;
                in_a = a_vec[h];
                in_b = b_vec[h];
            end else begin
                in_valid = 1'b0;
                if (h == stall_at && stalls < stall_len) stalls++;
            end
            if (in_valid && in_ready) h++;
            tick();
            l++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_accept", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_taps = '0; cfg_bias = '0; in_a = '0; in_b = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {8'd0, out_data}, 32'd0);
        chk("rst_aclr", {31'd0, mult_aclr}, 32'd1);
        chk("rst_sum", {8'd0, mult_sum}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("aclr_released", {31'd0, mult_aclr}, 32'd0);

        // Basic job: 10 + 6 - 20 + 7 = 3, out_valid at cycle 5.
        a_vec[0] = 8'sd2;  b_vec[0] = 8'sd3;
        a_vec[1] = -8'sd4; b_vec[1] = 8'sd5;
        a_vec[2] = 8'sd7;  b_vec[2] = 8'sd1;
        run_job(5'd3, 24'd10, 3, -1, 0, lat, hs);
        chk("j1_latency", lat, 32'd5);
        chk("j1_handshakes", hs, 32'd3);
        chk("j1_data", {8'd0, out_data}, 32'd3);
        chk("j1_busy_hold", {31'd0, busy}, 32'd1);
        release_out();

        // Same job with two stall cycles after the first pair.
        run_job(5'd3, 24'd10, 3, 1, 2, lat, hs);
        chk("j2_latency", lat, 32'd7);
        chk("j2_data", {8'd0, out_data}, 32'd3);
        release_out();

        // Negative sum: -64 + 1 = -63.
        a_vec[0] = -8'sd8; b_vec[0] = 8'sd8;
        a_vec[1] = 8'sd1;  b_vec[1] = 8'sd1;
        run_job(5'd2, 24'd0, 2, -1, 0, lat, hs);
        chk("j3_latency", lat, 32'd4);
`ifdef MAC_SEQUENCER_RELU_EN
        chk("j3_data_relu", {8'd0, out_data}, 32'd0);
`else
        chk("j3_data_raw", {8'd0, out_data}, 32'h00FF_FFC1);
`endif
        release_out();

        // Zero taps behaves as one tap: 100 + 5*(-3) = 85.
        a_vec[0] = 8'sd5; b_vec[0] = -8'sd3;
        a_vec[1] = 8'sd9; b_vec[1] = 8'sd9;
        run_job(5'd0, 24'd100, 2, -1, 0, lat, hs);
        chk("j4_handshakes", hs, 32'd1);
        chk("j4_latency", lat, 32'd3);
        chk("j4_data", {8'd0, out_data}, 32'd85);
        release_out();

        // Oversize request clamps to 25 taps: 25 * (1*2) = 50.
        for (int i = 0; i < 30; i++) begin
            a_vec[i] = 8'sd1;
            b_vec[i] = 8'sd2;
        end
        run_job(5'd31, 24'd0, 30, -1, 0, lat, hs);
        chk("j5_handshakes", hs, 32'd25);
        chk("j5_latency", lat, 32'd27);
        chk("j5_in_ready", {31'd0, in_ready}, 32'd0);
        chk("j5_data", {8'd0, out_data}, 32'd50);

        // HOLD with out_ready low: data stable, start ignored.
        held = out_data;
        cfg_taps = 5'd1;
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {8'd0, out_data}, {8'd0, held});
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk("accept_start_busy", {31'd0, busy}, 32'd0);
        chk("accept_start_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("no_job_busy", {31'd0, busy}, 32'd0);
        chk("no_job_in_ready", {31'd0, in_ready}, 32'd0);

        // Reset mid-job after two taps, then a fresh job.
        cfg_taps = 5'd4;
        cfg_bias = 24'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3;
        tick();
        in_a = 8'd2; in_b = 8'd2;
        tick();
        reset_n = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {8'd0, out_data}, 32'd0);
        chk("mid_rst_aclr", {31'd0, mult_aclr}, 32'd1);
        chk("mid_rst_mult", {16'd0, mult_dataa, mult_datab}, 32'd0);
        chk("mid_rst_sum", {8'd0, mult_sum}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_result", {8'd0, mult_result}, 32'd0);

        // Fresh job: 1 + 12 - 12 = 1.
        a_vec[0] = 8'sd3;  b_vec[0] = 8'sd4;
        a_vec[1] = -8'sd2; b_vec[1] = 8'sd6;
        run_job(5'd2, 24'd1, 2, -1, 0, lat, hs);
        chk("j6_latency", lat, 32'd4);
        chk("j6_data", {8'd0, out_data}, 32'd1);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequences the shared registered multiply-add unit (result = dataa·datab + sum, one-cycle latency, synchronous clear) through one convolution dot product. The block accepts a configurable number of operand pairs (kernel taps) over a valid/ready stream, feeds the running result back as the next addend, and presents one bias-seeded accumulated value per job on a valid/ready output. It sits between the window/weight fetch logic and the activation/pooling stage of the CNN datapath.

## Interface
- DATA_W, 8, operand width (signed two's complement)
- ACC_W, 24, accumulator / multiplier result width
- MAX_TAPS, 25, maximum taps per job (5×5 kernel)
- CNT_W, 5, tap counter width, ≥ clog2(MAX_TAPS+1)
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  job request; accepted only in IDLE
- cfg_taps  in  CNT_W  taps for this job; sampled with start
- cfg_bias  in  ACC_W  initial accumulator value; sampled with start
- busy  out  1  high in any state but IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a, in_b  in  DATA_W each  activation, weight
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  accumulated (optionally rectified) result
- mult_dataa, mult_datab  out  DATA_W each  to multiply-add unit
- mult_sum  out  ACC_W  addend to multiply-add unit
- mult_aclr  out  1  clear to multiply-add unit, = ~reset_n
- mult_result  in  ACC_W  registered result from multiply-add unit

## Operation
- Multiply-add unit configured signed, widthp = ACC_W; it updates every clock, so the sequencer drives dataa = datab = 0, sum = mult_result on every non-issue cycle (result holds).
- States: IDLE, ACCUM, DRAIN, HOLD.
- IDLE: in_ready = 0. On start: latch taps (0 → 1, > MAX_TAPS → MAX_TAPS), latch bias, clear tap count, → ACCUM.
- ACCUM: in_ready = 1. On handshake: issue in_a/in_b; mult_sum = bias for the first tap, mult_result for later taps; count++. Handshake on tap = taps → DRAIN. No handshake: hold pattern, stay.
- DRAIN: in_ready = 0, hold pattern; register mult_result (after optional ReLU) into out_data; → HOLD.
- HOLD: out_valid = 1, out_data stable; on out_ready → IDLE.
- start outside IDLE is ignored, including start concurrent with the final out_ready in HOLD.
- Arithmetic: products sign-extended to ACC_W; sum wraps modulo 2^ACC_W, no saturation. ACC_W ≥ 2·DATA_W + clog2(MAX_TAPS) gives exact results.
- Reset (including mid-job): state IDLE; busy, in_ready, out_valid = 0; out_data = 0; count = 0; mult_aclr = 1; mult_dataa/datab/sum = 0; the partial job is discarded.

## Timing
- Start accepted at cycle 0 → in_ready at cycle 1.
- With N taps and in_valid held high: handshakes at cycles 1..N, DRAIN at N+1, out_valid at N+2. Start-to-out_valid latency is N+2 cycles plus input stall cycles.
- Each input stall cycle adds exactly one cycle of latency; accumulated value unaffected.
- Minimum job period (out_ready held high): N+3 cycles.

## Configuration
- MAC_SEQUENCER_RELU_EN defined: in DRAIN, a negative mult_result (MSB = 1) is registered as 0 and a non-negative value passes unchanged.
- Undefined: out_data is the raw signed accumulation.

## Test plan
- taps=3, bias=10, pairs (2,3),(−4,5),(7,1), continuous valid → out_valid at cycle 5 (start at cycle 0), out_data = 10+6−20+7 = 3.
- Same job with in_valid low for 2 cycles after the first pair → identical out_data = 3, out_valid at cycle 7.
- taps=2, bias=0, pairs (−8,8),(1,1): out_data = −63 without the macro, 0 with MAC_SEQUENCER_RELU_EN.
- taps=0 → treated as one tap; taps=31 with MAX_TAPS=25 → exactly 25 handshakes accepted, then in_ready = 0.
- HOLD with out_ready low for 4 cycles → out_data stable and start ignored; out_ready & start in the same cycle → IDLE, no job begins, busy = 0 next cycle.
- reset_n low during ACCUM after 2 taps → next cycle all outputs 0 and state IDLE; a fresh job then yields the correct sum with no residue.
